// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue and writeback control for the FPU.
// Owns the FP register file and a per-register busy scoreboard. Launches ops
// into an external fixed-latency, fully pipelined FU and retires them in issue
// order through a tag pipeline whose depth matches the FU latency.
module fpu_issue_ctrl #(
  parameter int NREG   = 32,
  parameter int DW     = 32,
  parameter int FU_LAT = 4,
  parameter int BYPASS = 0,
  localparam int RW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [RW-1:0] x1,
  input  logic [RW-1:0] x2,
  input  logic [RW-1:0] y,
  input  logic [5:0]    operation,
  input  logic [DW-1:0] in_data,
  input  logic          ready,
  output logic          accept,
  output logic          valid,
  output logic [DW-1:0] out_data,
  output logic          cond,
  output logic          ex_start,
  output logic [5:0]    ex_op,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_cond
);

  localparam logic [5:0] FPU_OPSET = 6'h01;

  logic [DW-1:0]     regs_q    [NREG];
  logic [DW-1:0]     regs_d    [NREG];
  logic [NREG-1:0]   busy_q,    busy_d;
  logic [FU_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [FU_LAT-1:0] tag_set_q, tag_set_d;
  logic [FU_LAT-1:0] tag_cmp_q, tag_cmp_d;
  logic [RW-1:0]     tag_y_q   [FU_LAT];
  logic [RW-1:0]     tag_y_d   [FU_LAT];
  logic [DW-1:0]     tag_dat_q [FU_LAT];
  logic [DW-1:0]     tag_dat_d [FU_LAT];
  logic              valid_q,    valid_d;
  logic              cond_q,     cond_d;
  logic [DW-1:0]     out_data_q, out_data_d;

  logic          op_set, op_cmp, op_wr;
  logic          ret_vld, ret_wr;
  logic [RW-1:0] ret_y;
  logic [DW-1:0] ret_val;
  logic          x1_ret, x2_ret, y_ret;
  logic          x1_busy, x2_busy, y_busy;
  logic          hazard;

  // Decode the incoming command and the retire stage, then evaluate hazards.
  always_comb begin
    op_set  = (operation == FPU_OPSET);
    op_cmp  = operation[5];
    op_wr   = !op_cmp;
    ret_vld = tag_vld_q[FU_LAT-1];
    ret_wr  = ret_vld && !tag_cmp_q[FU_LAT-1];
    ret_y   = tag_y_q[FU_LAT-1];
    ret_val = tag_set_q[FU_LAT-1] ? tag_dat_q[FU_LAT-1] : ex_result;
    x1_ret  = ret_wr && (ret_y == x1);
    x2_ret  = ret_wr && (ret_y == x2);
    y_ret   = ret_wr && (ret_y == y);
    // A register whose writer retires this cycle is free for a new writer;
    // as a source it is only usable through the bypass.
    x1_busy = busy_q[x1] && !x1_ret;
    x2_busy = busy_q[x2] && !x2_ret;
    y_busy  = busy_q[y] && !y_ret;
    hazard  = (!op_set && (x1_busy || x2_busy ||
                           ((BYPASS == 0) && (x1_ret || x2_ret)))) ||
              (op_wr && y_busy);
  end

  assign accept   = ready && !hazard && rstn;
  assign ex_start = accept && !op_set;
  assign ex_op    = operation;
  assign ex_a     = ((BYPASS != 0) && x1_ret) ? ret_val : regs_q[x1];
  assign ex_b     = ((BYPASS != 0) && x2_ret) ? ret_val : regs_q[x2];
  assign valid    = valid_q;
  assign out_data = out_data_q;
  assign cond     = cond_q;

  // Tag pipeline: stage 0 captures the accepted command, then it shifts
  // every cycle in lockstep with the FU.
  always_comb begin
    tag_vld_d    = '0;
    tag_set_d    = '0;
    tag_cmp_d    = '0;
    tag_vld_d[0] = accept;
    tag_set_d[0] = op_set;
    tag_cmp_d[0] = op_cmp;
    tag_y_d[0]   = y;
    tag_dat_d[0] = in_data;
    for (int i = 1; i < FU_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_set_d[i] = tag_set_q[i-1];
      tag_cmp_d[i] = tag_cmp_q[i-1];
      tag_y_d[i]   = tag_y_q[i-1];
      tag_dat_d[i] = tag_dat_q[i-1];
    end
  end

  // Writeback and scoreboard update; a new issue to y wins over a retire
  // clearing the same busy bit.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    valid_d    = ret_vld;
    out_data_d = ret_vld ? ret_val : out_data_q;
    cond_d     = (ret_vld && tag_cmp_q[FU_LAT-1]) ? ex_cond : cond_q;
    if (ret_wr) begin
      regs_d[ret_y] = ret_val;
      busy_d[ret_y] = 1'b0;
    end
    if (accept && op_wr) begin
      busy_d[y] = 1'b1;
    end
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < FU_LAT; i++) begin
        tag_y_q[i]   <= '0;
        tag_dat_q[i] <= '0;
      end
      busy_q     <= '0;
      tag_vld_q  <= '0;
      tag_set_q  <= '0;
      tag_cmp_q  <= '0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
      cond_q     <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      tag_vld_q  <= tag_vld_d;
      tag_set_q  <= tag_set_d;
      tag_cmp_q  <= tag_cmp_d;
      tag_y_q    <= tag_y_d;
      tag_dat_q  <= tag_dat_d;
      valid_q    <= valid_d;
      out_data_q <= out_data_d;
      cond_q     <= cond_d;
    end
  end

endmodule
